// File: rtl/reg_bank_sequencer_if.sv
// Command port of one requester: a held request with its operation, target, repeat count and data,
// answered by a one-cycle grant when the sequencer latches it.
interface reg_bank_sequencer_if #(
  parameter int NBits = 16,
  parameter int SW    = 2,
  parameter int CW    = 8
);
  logic             req;
  logic [1:0]       op;
  logic [SW-1:0]    sel;
  logic [CW-1:0]    cnt;
  logic [NBits-1:0] data;
  logic             gnt;

  modport master (output req, op, sel, cnt, data, input gnt);
  modport slave  (input req, op, sel, cnt, data, output gnt);
endinterface

// File: rtl/reg_bank_sequencer.sv
// Round-robin arbiter plus funsel/e waveform sequencer for a bank of NREGS registers; done comes
// 3 cycles after gnt for clear/load, 1+2N for inc/dec by N; requesters wait with req held while busy.
module reg_bank_sequencer #(
  parameter  int NBits = 16,
  parameter  int NREGS = 4,
  parameter  int CW    = 8,
  localparam int SW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_bank_sequencer_if.slave   cmd_a,
  reg_bank_sequencer_if.slave   cmd_b,
  output logic                  busy,
  output logic                  done,
  output logic [2*NREGS-1:0]    reg_funsel,
  output logic [NREGS-1:0]      reg_e,
  output logic [NBits-1:0]      reg_i
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

  state_t           state, state_nxt;
  logic             last_b;
  logic [1:0]       cur_op;
  logic [SW-1:0]    cur_sel;
  logic [CW-1:0]    cur_cnt;
  logic [NBits-1:0] cur_data;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    setup_rem;
  logic             take_a, take_b;

  // clear/load need a single e pulse; inc/dec need one rising edge per count
  assign setup_rem = cur_op[1] ? cur_cnt : CW'(1);

  assign cmd_a.gnt = take_a;
  assign cmd_b.gnt = take_b;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_a     = 1'b0;
    take_b     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    reg_funsel = '0;
    reg_e      = '0;
    reg_i      = '0;
    case (state)
      IDLE: begin
        take_a = cmd_a.req && (!cmd_b.req || last_b);
        take_b = cmd_b.req && (!cmd_a.req || !last_b);
        if (take_a || take_b) state_nxt = SETUP;
      end
      SETUP: begin
        busy = 1'b1;
        if (setup_rem == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        busy           = 1'b1;
        reg_e[cur_sel] = 1'b1;
        state_nxt      = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (remaining == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = PULSE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // funsel and data are driven from SETUP onward so they are settled before e rises
    if (busy) begin
      reg_funsel[{cur_sel, 1'b0} +: 2] = cur_op;
      reg_i                            = cur_data;
    end
    if (reset) begin
      take_a = 1'b0;
      take_b = 1'b0;
      done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b    <= 1'b1;
      cur_op    <= '0;
      cur_sel   <= '0;
      cur_cnt   <= '0;
      cur_data  <= '0;
      remaining <= '0;
    end else begin
      if (take_a) begin
        cur_op   <= cmd_a.op;
        cur_sel  <= cmd_a.sel;
        cur_cnt  <= cmd_a.cnt;
        cur_data <= cmd_a.data;
        last_b   <= 1'b0;
      end else if (take_b) begin
        cur_op   <= cmd_b.op;
        cur_sel  <= cmd_b.sel;
        cur_cnt  <= cmd_b.cnt;
        cur_data <= cmd_b.data;
        last_b   <= 1'b1;
      end
      if (state == SETUP)    remaining <= setup_rem;
      else if (state == GAP) remaining <= remaining - CW'(1);
    end
  end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Drives both requesters into a behavioural register bank and checks timing and register contents
// against arithmetic expectations (value +/- count, 1+2N latency).
module tb_reg_bank_sequencer;
  localparam int NBits = 16;
  localparam int NREGS = 4;
  localparam int SW    = 2;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_bank_sequencer_if #(.NBits(NBits), .SW(SW), .CW(CW)) cmd_a ();
  reg_bank_sequencer_if #(.NBits(NBits), .SW(SW), .CW(CW)) cmd_b ();
  logic                 busy, done;
  logic [2*NREGS-1:0]   reg_funsel;
  logic [NREGS-1:0]     reg_e;
  logic [NBits-1:0]     reg_i;

  reg_bank_sequencer #(.NBits(NBits), .NREGS(NREGS), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cmd_a(cmd_a), .cmd_b(cmd_b), .busy(busy), .done(done),
    .reg_funsel(reg_funsel), .reg_e(reg_e), .reg_i(reg_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register bank: clear/load while e high, inc/dec on the rising edge of e
  logic [NBits-1:0] bank [NREGS];
  logic [NREGS-1:0] e_q = '0;
  logic             bank_init = 1'b0;
  always @(posedge clk) begin
    e_q <= reg_e;
    for (int k = 0; k < NREGS; k++) begin
      if (bank_init) bank[k] <= '0;
      else if (reg_e[k]) begin
        case (reg_funsel[2*k +: 2])
          2'b00:   bank[k] <= '0;
          2'b01:   bank[k] <= reg_i;
          2'b10:   if (!e_q[k]) bank[k] <= bank[k] - 1'b1;
          default: if (!e_q[k]) bank[k] <= bank[k] + 1'b1;
        endcase
      end
    end
  end

  // protocol watcher: counts grants/dones and any rule breach
  int n_ga = 0, n_gb = 0, n_done = 0, viol = 0;
  logic [NREGS-1:0]   pe = '0;
  logic [2*NREGS-1:0] pf = '0;
  logic [NBits-1:0]   pi = '0;
  always @(negedge clk) begin
    if (cmd_a.gnt) n_ga++;
    if (cmd_b.gnt) n_gb++;
    if (done) n_done++;
    if (cmd_a.gnt && cmd_b.gnt) viol++;
    if (done && (cmd_a.gnt || cmd_b.gnt)) viol++;
    if ((reg_e & pe) != '0) viol++;
    if ($countones(reg_e) > 1) viol++;
    if (reg_e != '0 && (reg_funsel != pf || reg_i != pi)) viol++;
    pe = reg_e;
    pf = reg_funsel;
    pi = reg_i;
  end

  logic [NBits-1:0] exp_reg [NREGS];

  function automatic void model(input logic [1:0] op, input int sel, input int cnt, input logic [NBits-1:0] data);
    case (op)
      2'b00:   exp_reg[sel] = '0;
      2'b01:   exp_reg[sel] = data;
      2'b10:   exp_reg[sel] = exp_reg[sel] - NBits'(cnt);
      default: exp_reg[sel] = exp_reg[sel] + NBits'(cnt);
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input int cnt);
    return op[1] ? 1 + 2 * cnt : 3;
  endfunction

  function automatic int exp_pulses(input logic [1:0] op, input int cnt);
    return op[1] ? cnt : 1;
  endfunction

  task automatic drive(input bit is_b, input bit rq, input logic [1:0] op, input int sel, input int cnt,
                       input logic [NBits-1:0] data);
    if (is_b) begin
      cmd_b.req = rq; cmd_b.op = op; cmd_b.sel = sel[SW-1:0]; cmd_b.cnt = cnt[CW-1:0]; cmd_b.data = data;
    end else begin
      cmd_a.req = rq; cmd_a.op = op; cmd_a.sel = sel[SW-1:0]; cmd_a.cnt = cnt[CW-1:0]; cmd_a.data = data;
    end
  endtask

  task automatic scramble_drop(input bit is_b);
    drive(is_b, 1'b0, 2'($urandom), int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, 255)), 16'($urandom));
  endtask

  // issues one command and reports grant/done cycles, busy length, e pulses and SETUP funsel
  task automatic do_cmd(input bit is_b, input logic [1:0] op, input int sel, input int cnt,
                        input logic [NBits-1:0] data, output int g, output int d, output int busy_n,
                        output int pulses, output int stray, output logic [2*NREGS-1:0] fs_setup, output bit to);
    to = 0; g = -1; d = -1; busy_n = 0; pulses = 0; stray = 0; fs_setup = '0;
    @(posedge clk); #1;
    drive(is_b, 1'b1, op, sel, cnt, data);
    for (int i = 0; i < 50 && g < 0; i++) begin
      @(negedge clk);
      if (is_b ? cmd_b.gnt : cmd_a.gnt) g = cyc;
    end
    @(posedge clk); #1;
    scramble_drop(is_b);
    if (g < 0) begin to = 1; return; end
    for (int i = 0; i < 600 && d < 0; i++) begin
      @(negedge clk);
      if (i == 0) fs_setup = reg_funsel;
      if (busy) busy_n++;
      if (reg_e[sel]) pulses++;
      if ((reg_e & ~(NREGS'(1) << sel)) != '0) stray++;
      if (done) d = cyc;
    end
    if (d < 0) to = 1;
  endtask

  task automatic test_reset;
    reset = 1'b1; bank_init = 1'b1;
    drive(0, 1'b1, 2'b01, 1, 0, 16'h1234);
    drive(1, 1'b0, 2'b00, 0, 0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_a.gnt !== 1'b0 || cmd_b.gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: got a=%b b=%b want 0 0", cmd_a.gnt, cmd_b.gnt);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_done: got %b want 00", {busy, done});
    end
    checks++;
    if (reg_e !== '0 || reg_funsel !== '0 || reg_i !== '0) begin
      errors++; $display("FAIL reset_outs: got e=%h fs=%h i=%h want 0", reg_e, reg_funsel, reg_i);
    end
    @(posedge clk); #1;
    reset = 1'b0; bank_init = 1'b0; cmd_a.req = 1'b0;
    for (int k = 0; k < NREGS; k++) exp_reg[k] = '0;
  endtask

  task automatic test_load;
    int g, d, bn, p, s; logic [2*NREGS-1:0] fs; bit to;
    do_cmd(0, 2'b01, 2, 0, 16'hBEEF, g, d, bn, p, s, fs, to);
    model(2'b01, 2, 0, 16'hBEEF);
    checks++;
    if (to || d - g != 3 || bn != 3) begin
      errors++; $display("FAIL load_timing: got lat=%0d busy=%0d timeout=%0d want 3 3 0", d - g, bn, to);
    end
    checks++;
    if (p != 1 || s != 0) begin
      errors++; $display("FAIL load_pulses: got %0d stray=%0d want 1 0", p, s);
    end
    for (int k = 0; k < NREGS; k++) begin
      checks++;
      if (bank[k] !== exp_reg[k]) begin
        errors++; $display("FAIL load_reg%0d: got %h want %h", k, bank[k], exp_reg[k]);
      end
    end
  endtask

  task automatic test_increment;
    int g, d, bn, p, s; logic [2*NREGS-1:0] fs; bit to;
    do_cmd(0, 2'b01, 1, 0, 16'd5, g, d, bn, p, s, fs, to);
    model(2'b01, 1, 0, 16'd5);
    do_cmd(0, 2'b11, 1, 3, 16'h0, g, d, bn, p, s, fs, to);
    model(2'b11, 1, 3, 16'h0);
    checks++;
    if (to || d - g != 7 || bn != 7) begin
      errors++; $display("FAIL inc_timing: got lat=%0d busy=%0d timeout=%0d want 7 7 0", d - g, bn, to);
    end
    checks++;
    if (p != 3 || s != 0) begin
      errors++; $display("FAIL inc_pulses: got %0d stray=%0d want 3 0", p, s);
    end
    checks++;
    if (fs !== 8'b00_00_11_00) begin
      errors++; $display("FAIL inc_setup_funsel: got %b want 00001100", fs);
    end
    checks++;
    if (bank[1] !== 16'd8 || bank[1] !== exp_reg[1]) begin
      errors++; $display("FAIL inc_reg1: got %h want %h", bank[1], exp_reg[1]);
    end
  endtask

  task automatic test_alternation;
    int gc[4], dc[4]; bit who[4]; int ng = 0, nd = 0; bit dropped = 0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    drive(0, 1'b1, 2'b00, 0, 0, 16'h0);
    drive(1, 1'b1, 2'b00, 3, 0, 16'h0);
    for (int i = 0; i < 80 && nd < 4; i++) begin
      @(negedge clk);
      if ((cmd_a.gnt || cmd_b.gnt) && ng < 4) begin
        who[ng] = cmd_b.gnt; gc[ng] = cyc; ng++;
      end
      if (done && nd < 4) begin dc[nd] = cyc; nd++; end
      if (ng == 4 && !dropped) begin
        @(posedge clk); #1;
        cmd_a.req = 1'b0; cmd_b.req = 1'b0; dropped = 1;
      end
    end
    cmd_a.req = 1'b0; cmd_b.req = 1'b0;
    model(2'b00, 0, 0, 16'h0); model(2'b00, 3, 0, 16'h0);
    checks++;
    if (ng != 4 || nd != 4) begin
      errors++; $display("FAIL alt_count: got grants=%0d dones=%0d want 4 4", ng, nd);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (who[i] !== bit'(i % 2)) begin
          errors++; $display("FAIL alt_order%0d: got %s want %s", i, who[i] ? "B" : "A", (i % 2) ? "B" : "A");
        end
        if (i > 0) begin
          checks++;
          if (gc[i] != dc[i-1] + 1) begin
            errors++; $display("FAIL alt_regrant%0d: got gap=%0d want 1", i, gc[i] - dc[i-1]);
          end
        end
      end
    end
    checks++;
    if (bank[0] !== exp_reg[0] || bank[3] !== exp_reg[3]) begin
      errors++; $display("FAIL alt_regs: got %h %h want %h %h", bank[0], bank[3], exp_reg[0], exp_reg[3]);
    end
  endtask

  task automatic test_count_zero_wrap;
    int g, d, bn, p, s; logic [2*NREGS-1:0] fs; bit to;
    logic [NBits-1:0] v;
    v = 16'($urandom);
    do_cmd(1, 2'b01, 0, 0, v, g, d, bn, p, s, fs, to);
    model(2'b01, 0, 0, v);
    do_cmd(1, 2'b10, 0, 0, 16'h0, g, d, bn, p, s, fs, to);
    model(2'b10, 0, 0, 16'h0);
    checks++;
    if (to || d - g != 1 || bn != 1 || p != 0) begin
      errors++; $display("FAIL zero_cnt: got lat=%0d busy=%0d pulses=%0d want 1 1 0", d - g, bn, p);
    end
    checks++;
    if (bank[0] !== v) begin
      errors++; $display("FAIL zero_cnt_reg0: got %h want %h", bank[0], v);
    end
    do_cmd(1, 2'b00, 0, 0, 16'h0, g, d, bn, p, s, fs, to);
    model(2'b00, 0, 0, 16'h0);
    do_cmd(1, 2'b10, 0, 1, 16'h0, g, d, bn, p, s, fs, to);
    model(2'b10, 0, 1, 16'h0);
    checks++;
    if (to || d - g != 3 || p != 1) begin
      errors++; $display("FAIL wrap_timing: got lat=%0d pulses=%0d want 3 1", d - g, p);
    end
    checks++;
    if (bank[0] !== 16'hFFFF || exp_reg[0] !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_reg0: got %h want ffff", bank[0]);
    end
  endtask

  task automatic test_reset_mid;
    int g, d, bn, p, s, done0; logic [2*NREGS-1:0] fs; bit to; logic [NBits-1:0] v, w;
    v = 16'($urandom); w = 16'($urandom);
    do_cmd(0, 2'b01, 3, 0, v, g, d, bn, p, s, fs, to);
    model(2'b01, 3, 0, v);
    g = -1;
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b11, 3, 5, 16'h0);
    for (int i = 0; i < 50 && g < 0; i++) begin
      @(negedge clk);
      if (cmd_a.gnt) g = cyc;
    end
    @(posedge clk); #1;
    scramble_drop(0);
    repeat (4) @(posedge clk);
    #1;
    done0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (g < 0 || busy !== 1'b1 || reg_e !== '0) begin
      errors++; $display("FAIL rmid_in_gap: got busy=%b e=%b want 1 0", busy, reg_e);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (reg_e !== '0 || busy !== 1'b0 || reg_funsel !== '0) begin
      errors++; $display("FAIL rmid_idle: got e=%b busy=%b fs=%b want 0 0 0", reg_e, busy, reg_funsel);
    end
    model(2'b11, 3, 2, 16'h0);
    checks++;
    if (bank[3] !== exp_reg[3]) begin
      errors++; $display("FAIL rmid_reg3: got %h want %h", bank[3], exp_reg[3]);
    end
    @(posedge clk); #1;
    checks++;
    if (n_done != done0) begin
      errors++; $display("FAIL rmid_no_done: got %0d dones want 0", n_done - done0);
    end
    drive(0, 1'b1, 2'b01, 1, 0, w);
    drive(1, 1'b1, 2'b01, 2, 0, ~w);
    @(negedge clk);
    checks++;
    if (cmd_a.gnt !== 1'b1 || cmd_b.gnt !== 1'b0) begin
      errors++; $display("FAIL rmid_tie: got a=%b b=%b want 1 0", cmd_a.gnt, cmd_b.gnt);
    end
    @(posedge clk); #1;
    cmd_a.req = 1'b0; cmd_b.req = 1'b0;
    d = -1;
    for (int i = 0; i < 20 && d < 0; i++) begin
      @(negedge clk);
      if (done) d = i;
    end
    model(2'b01, 1, 0, w);
    checks++;
    if (d < 0 || bank[1] !== exp_reg[1]) begin
      errors++; $display("FAIL rmid_after: got reg1=%h done_at=%0d want %h", bank[1], d, exp_reg[1]);
    end
  endtask

  task automatic test_withdraw;
    int g = -1, ga0, p = 0, s = 0, nd = 0;
    @(posedge clk); #1;
    drive(1, 1'b1, 2'b11, 0, 4, 16'h0);
    for (int i = 0; i < 50 && g < 0; i++) begin
      @(negedge clk);
      if (cmd_b.gnt) g = cyc;
    end
    @(posedge clk); #1;
    scramble_drop(1);
    ga0 = n_ga;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (reg_e[0]) p++;
      if (reg_e[NREGS-1:1] != '0) s++;
      if (done) nd++;
      @(posedge clk); #1;
      if (i == 1) drive(0, 1'b1, 2'b01, 1, 0, 16'hDEAD);
      if (i == 4) cmd_a.req = 1'b0;
    end
    model(2'b11, 0, 4, 16'h0);
    checks++;
    if (g < 0 || n_ga != ga0) begin
      errors++; $display("FAIL withdraw_gnt: got %0d A grants want 0", n_ga - ga0);
    end
    checks++;
    if (p != 4 || s != 0 || nd != 1) begin
      errors++; $display("FAIL withdraw_pulses: got p=%0d stray=%0d done=%0d want 4 0 1", p, s, nd);
    end
    checks++;
    if (bank[0] !== exp_reg[0] || bank[1] !== exp_reg[1]) begin
      errors++; $display("FAIL withdraw_regs: got %h %h want %h %h", bank[0], bank[1], exp_reg[0], exp_reg[1]);
    end
  endtask

  task automatic test_random;
    int g, d, bn, p, s, sel, cnt; logic [2*NREGS-1:0] fs; bit to, is_b; logic [1:0] op; logic [NBits-1:0] v;
    for (int n = 0; n < 25; n++) begin
      is_b = 1'($urandom); op = 2'($urandom); sel = int'($urandom_range(0, NREGS-1));
      cnt = int'($urandom_range(0, 6)); v = 16'($urandom);
      do_cmd(is_b, op, sel, cnt, v, g, d, bn, p, s, fs, to);
      model(op, sel, cnt, v);
      checks++;
      if (to || d - g != exp_lat(op, cnt) || bn != d - g) begin
        errors++; $display("FAIL rand%0d_lat: got %0d busy=%0d want %0d", n, d - g, bn, exp_lat(op, cnt));
      end
      checks++;
      if (p != exp_pulses(op, cnt) || s != 0) begin
        errors++; $display("FAIL rand%0d_pulses: got %0d stray=%0d want %0d", n, p, s, exp_pulses(op, cnt));
      end
      checks++;
      if (bank[sel] !== exp_reg[sel]) begin
        errors++; $display("FAIL rand%0d_reg%0d: got %h want %h", n, sel, bank[sel], exp_reg[sel]);
      end
    end
  endtask

  task automatic test_invariants;
    @(posedge clk); #1;
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL protocol_rules: got %0d breaches want 0", viol);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 2'b00, 0, 0, 16'h0);
    drive(1, 1'b0, 2'b00, 0, 0, 16'h0);
    test_reset;
    test_load;
    test_increment;
    test_alternation;
    test_count_zero_wrap;
    test_reset_mid;
    test_withdraw;
    test_random;
    test_invariants;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
